// File: rtl/drum_voice_if.sv
// -----------------------------------------------------------------------------
// drum_voice_if
//
// Groups the pad inputs and the audio/amplifier outputs of drum_voice_engine.
//
// Signal summary (NUM_CH = number of pads):
//   drum     [NUM_CH]  raw pad levels, asynchronous, active high
//   led      [NUM_CH]  debounced pad levels
//   active   [NUM_CH]  channel k is playing (this is the channel FSM state)
//   speaker            mixed square-wave output, registered
//   gain               amplifier gain select
//   shutdown           amplifier enable (1 = on)
//
// There is no valid/ready handshake on this interface: drum is a free-running
// asynchronous level, and every output is a registered level that is valid on
// every sysclk cycle once reset is released.
//
// Modports:
//   master  drives drum, observes everything else (pad front end / bench)
//   slave   the engine itself
// -----------------------------------------------------------------------------
interface drum_voice_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] drum;
    logic [NUM_CH-1:0] led;
    logic [NUM_CH-1:0] active;
    logic              speaker;
    logic              gain;
    logic              shutdown;

    modport master (output drum, input led, input active, input speaker,
                    input gain, input shutdown);
    modport slave  (input drum, output led, output active, output speaker,
                    output gain, output shutdown);
endinterface

// File: rtl/drum_voice_engine.sv
// -----------------------------------------------------------------------------
// drum_voice_engine
//
// Multi-pad drum voice generator. Each raw pad input is synchronised and
// debounced; a debounced rising edge triggers its channel, which plays a
// fixed-pitch square wave for a fixed number of ticks. Active voices are mixed
// onto one speaker pin, and the amplifier control pins are driven.
//
// Ports:
//   sysclk  in   system clock
//   rst_n   in   asynchronous reset, active low
//   bus     drum_voice_if.slave
//             drum in, led/active/speaker/gain/shutdown out
//
// Channel k: duration DUR_BASE<<k ticks, half-period HP_BASE-k*HP_STEP ticks.
// All audio counters advance only on the prescaler tick (every CLKDIV cycles).
// The per-channel FSM state is visible directly on bus.active.
// -----------------------------------------------------------------------------
module drum_voice_engine #(
    parameter int NUM_CH    = 4,
    parameter int CLKDIV    = 4,
    parameter int DEB_TICKS = 16,
    parameter int DUR_BASE  = 2048,
    parameter int DUR_W     = 16,
    parameter int HP_BASE   = 512,
    parameter int HP_STEP   = 64,
    parameter int HP_W      = 10,
    parameter int MIX_MODE  = 0
) (
    input  logic        sysclk,
    input  logic        rst_n,
    drum_voice_if.slave bus
);

    localparam int PRE_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int DEB_W = $clog2(DEB_TICKS + 1);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } ch_state_t;

    // ---------------------------------------------------------------- prescaler
    logic [PRE_W-1:0] pre_cnt;
    logic             tick;

    assign tick = (pre_cnt == PRE_W'(CLKDIV - 1));

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // ------------------------------------------------ sync, debounce, trigger
    logic [NUM_CH-1:0] sync1;
    logic [NUM_CH-1:0] sync2;
    logic [NUM_CH-1:0] led_q;
    logic [NUM_CH-1:0] led_d;
    logic [NUM_CH-1:0] trig;
    logic [DEB_W-1:0]  deb_cnt [NUM_CH];

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            led_q <= '0;
            led_d <= '0;
            trig  <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                deb_cnt[k] <= '0;
            end
        end else begin
            sync1 <= bus.drum;
            sync2 <= sync1;
            led_d <= led_q;
            // Registered rise detect: trig is high the cycle after led rises.
            trig  <= led_q & ~led_d;
            if (tick) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (sync2[k] != led_q[k]) begin
                        // The DEB_TICKS-th consecutive differing tick flips led.
                        if (deb_cnt[k] == DEB_W'(DEB_TICKS - 1)) begin
                            led_q[k]   <= ~led_q[k];
                            deb_cnt[k] <= '0;
                        end else begin
                            deb_cnt[k] <= deb_cnt[k] + 1'b1;
                        end
                    end else begin
                        deb_cnt[k] <= '0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------ channel FSMs
    ch_state_t         state_q [NUM_CH];
    ch_state_t         state_n [NUM_CH];
    logic [DUR_W-1:0]  dur_q   [NUM_CH];
    logic [DUR_W-1:0]  dur_n   [NUM_CH];
    logic [HP_W-1:0]   phase_q [NUM_CH];
    logic [HP_W-1:0]   phase_n [NUM_CH];
    logic [NUM_CH-1:0] wave_q;
    logic [NUM_CH-1:0] wave_n;
    logic [NUM_CH-1:0] active_c;

    function automatic logic [DUR_W-1:0] dur_reload(input int k);
        return DUR_W'((DUR_BASE << k) - 1);
    endfunction

    function automatic logic [HP_W-1:0] hp_reload(input int k);
        return HP_W'(HP_BASE - k * HP_STEP - 1);
    endfunction

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                state_q[k] <= IDLE;
                dur_q[k]   <= '0;
                phase_q[k] <= '0;
            end
            wave_q <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                state_q[k] <= state_n[k];
                dur_q[k]   <= dur_n[k];
                phase_q[k] <= phase_n[k];
            end
            wave_q <= wave_n;
        end
    end

    always_comb begin
        wave_n = wave_q;
        for (int k = 0; k < NUM_CH; k++) begin
            state_n[k] = state_q[k];
            dur_n[k]   = dur_q[k];
            phase_n[k] = phase_q[k];
            // A trigger (re)starts the note from scratch, and takes priority
            // over the final tick so a retrigger never drops to IDLE.
            if (trig[k]) begin
                state_n[k] = PLAY;
                dur_n[k]   = dur_reload(k);
                phase_n[k] = hp_reload(k);
                wave_n[k]  = 1'b0;
            end else if ((state_q[k] == PLAY) && tick) begin
                if (phase_q[k] == '0) begin
                    wave_n[k]  = ~wave_q[k];
                    phase_n[k] = hp_reload(k);
                end else begin
                    phase_n[k] = phase_q[k] - 1'b1;
                end
                if (dur_q[k] == '0) begin
                    state_n[k] = IDLE;
                    wave_n[k]  = 1'b0;
                end else begin
                    dur_n[k] = dur_q[k] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        active_c = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            active_c[k] = (state_q[k] == PLAY);
        end
    end

    // ------------------------------------------------------ mixer and amp pins
    logic mix_c;
    logic speaker_q;
    logic gain_q;
    logic shutdown_q;

    always_comb begin
        mix_c = 1'b0;
        if (MIX_MODE == 0) begin
            // Ascending scan: the last active channel seen is the highest index.
            for (int k = 0; k < NUM_CH; k++) begin
                if (active_c[k]) begin
                    mix_c = wave_q[k];
                end
            end
        end else begin
            mix_c = |(wave_q & active_c);
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            speaker_q  <= 1'b0;
            gain_q     <= 1'b0;
            shutdown_q <= 1'b0;
        end else begin
            speaker_q  <= mix_c;
            gain_q     <= 1'b1;
            shutdown_q <= |active_c;
        end
    end

    assign bus.led      = led_q;
    assign bus.active   = active_c;
    assign bus.speaker  = speaker_q;
    assign bus.gain     = gain_q;
    assign bus.shutdown = shutdown_q;

endmodule

// File: tb/tb_drum_voice_engine.sv
// -----------------------------------------------------------------------------
// tb_drum_voice_engine
//
// Two engines (MIX_MODE 0 and 1) share one pad stimulus. A cycle-level
// reference model, built from the documented latencies, is compared against
// both engines on every falling edge. A table of pad vectors with
// hand-computed activity counts is applied in a loop, followed by hand-written
// sequences for reset, retrigger, mix priority and reset mid-play.
// -----------------------------------------------------------------------------
module tb_drum_voice_engine;

    localparam int NUM_CH   = 4;
    localparam int MAXC     = 4096;
    localparam int DUR_BASE = 8;
    localparam int HP_BASE  = 4;
    localparam int HP_STEP  = 1;

    // ------------------------------------------------------ clock / reset
    logic sysclk = 1'b0;
    logic rst_n  = 1'b0;
    logic [NUM_CH-1:0] drum = '0;

    always #5 sysclk = ~sysclk;

    int cyc;
    always @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    drum_voice_if #(.NUM_CH(NUM_CH)) bus0 ();
    drum_voice_if #(.NUM_CH(NUM_CH)) bus1 ();
    assign bus0.drum = drum;
    assign bus1.drum = drum;

    drum_voice_engine #(
        .NUM_CH(NUM_CH), .CLKDIV(2), .DEB_TICKS(3), .DUR_BASE(DUR_BASE),
        .DUR_W(8), .HP_BASE(HP_BASE), .HP_STEP(HP_STEP), .HP_W(4), .MIX_MODE(0)
    ) dut0 (
        .sysclk(sysclk), .rst_n(rst_n), .bus(bus0)
    );

    drum_voice_engine #(
        .NUM_CH(NUM_CH), .CLKDIV(2), .DEB_TICKS(3), .DUR_BASE(DUR_BASE),
        .DUR_W(8), .HP_BASE(HP_BASE), .HP_STEP(HP_STEP), .HP_W(4), .MIX_MODE(1)
    ) dut1 (
        .sysclk(sysclk), .rst_n(rst_n), .bus(bus1)
    );

    // ------------------------------------------------------ scoreboard state
    int n_checks;
    int n_fail;
    logic [0:0] exp_q[$];

    bit led_rise_at [NUM_CH][MAXC];
    bit led_fall_at [NUM_CH][MAXC];
    bit entry_at    [NUM_CH][MAXC];

    logic [NUM_CH-1:0] m_led, m_act, m_wave, p_act, p_wave;
    int   last_s [NUM_CH];
    bit   has_s  [NUM_CH];

    // window statistics for the vector table and sequences
    bit                win_en;
    int                act_cnt [NUM_CH];
    logic [NUM_CH-1:0] led_seen;
    int                rise0, rise1, act2_falls, last_act2;
    logic              prev_spk0, prev_spk1, prev_act2;

    typedef struct packed {
        logic [3:0]      pads;
        int              hold;
        int              gap;
        bit              settles;
        logic [3:0]      exp_led;
        logic [3:0][7:0] exp_act;
        int              exp_rise0;
        int              exp_rise1;
    } vec_t;

    vec_t vec [5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    // Edge at which led changes for a clean pad change applied after edge n:
    // two sync flops, then DEB_TICKS (=3) ticks on even edges.
    function automatic int settle_edge(input int n);
        int t1;
        t1 = ((n + 3) % 2 == 0) ? n + 3 : n + 4;
        return t1 + 4;
    endfunction

    task automatic mark_rise(input int k, input int n);
        int e;
        e = settle_edge(n);
        if (e + 2 < MAXC) begin
            led_rise_at[k][e]    = 1'b1;
            entry_at[k][e + 2]   = 1'b1;
        end
    endtask

    task automatic mark_fall(input int k, input int n);
        int e;
        e = settle_edge(n);
        if (e < MAXC) led_fall_at[k][e] = 1'b1;
    endtask

    task automatic clear_events();
        for (int k = 0; k < NUM_CH; k++) begin
            for (int c = 0; c < MAXC; c++) begin
                led_rise_at[k][c] = 1'b0;
                led_fall_at[k][c] = 1'b0;
                entry_at[k][c]    = 1'b0;
            end
        end
    endtask

    // Called at posedge+1. Clean changes are entered into the model.
    task automatic set_pads(input logic [3:0] v, input bit settles);
        for (int k = 0; k < NUM_CH; k++) begin
            if (settles && v[k] && !drum[k]) mark_rise(k, cyc);
            if (settles && !v[k] && drum[k]) mark_fall(k, cyc);
        end
        drum = v;
    endtask

    // Falling-edge comparison of both engines against the reference model.
    task automatic cycle_check();
        logic exp_spk0, exp_spk1, exp_sd, exp_gain;
        if (!rst_n) begin
            m_led = '0; m_act = '0; m_wave = '0; p_act = '0; p_wave = '0;
            for (int k = 0; k < NUM_CH; k++) has_s[k] = 1'b0;
            exp_spk0 = 1'b0; exp_spk1 = 1'b0; exp_sd = 1'b0; exp_gain = 1'b0;
        end else begin
            exp_spk0 = 1'b0;
            for (int k = 0; k < NUM_CH; k++) if (p_act[k]) exp_spk0 = p_wave[k];
            exp_spk1 = |(p_act & p_wave);
            exp_sd   = |p_act;
            exp_gain = (cyc >= 1);
            for (int k = 0; k < NUM_CH; k++) begin
                if (cyc < MAXC) begin
                    if (led_rise_at[k][cyc]) m_led[k] = 1'b1;
                    if (led_fall_at[k][cyc]) m_led[k] = 1'b0;
                    if (entry_at[k][cyc]) begin
                        last_s[k] = cyc;
                        has_s[k]  = 1'b1;
                    end
                end
                m_act[k]  = has_s[k] && (cyc < last_s[k] + 2 * (DUR_BASE << k));
                m_wave[k] = m_act[k] &&
                            ((((cyc - last_s[k]) / 2) / (HP_BASE - k * HP_STEP)) % 2 == 1);
            end
        end
        check("led0",      32'(bus0.led),      32'(m_led));
        check("active0",   32'(bus0.active),   32'(m_act));
        check("speaker0",  32'(bus0.speaker),  32'(exp_spk0));
        check("shutdown0", 32'(bus0.shutdown), 32'(exp_sd));
        check("gain0",     32'(bus0.gain),     32'(exp_gain));
        check("led1",      32'(bus1.led),      32'(m_led));
        check("active1",   32'(bus1.active),   32'(m_act));
        check("speaker1",  32'(bus1.speaker),  32'(exp_spk1));
        check("shutdown1", 32'(bus1.shutdown), 32'(exp_sd));
        check("gain1",     32'(bus1.gain),     32'(exp_gain));
        p_act  = m_act;
        p_wave = m_wave;

        if (win_en) begin
            for (int k = 0; k < NUM_CH; k++) act_cnt[k] += int'(bus0.active[k]);
            led_seen = led_seen | bus0.led;
            if (bus0.speaker && !prev_spk0) rise0++;
            if (bus1.speaker && !prev_spk1) rise1++;
            if (!bus0.active[2] && prev_act2) act2_falls++;
            if (bus0.active[2]) last_act2 = cyc;
            prev_spk0 = bus0.speaker;
            prev_spk1 = bus1.speaker;
            prev_act2 = bus0.active[2];
        end
    endtask

    task automatic win_start();
        for (int k = 0; k < NUM_CH; k++) act_cnt[k] = 0;
        led_seen = '0; rise0 = 0; rise1 = 0; act2_falls = 0; last_act2 = -1;
        prev_spk0 = 1'b0; prev_spk1 = 1'b0; prev_act2 = 1'b0;
        win_en = 1'b1;
    endtask

    // ------------------------------------------------------ driver tasks
    // Entered and left at posedge+1; checks the model on each falling edge.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge sysclk);
            cycle_check();
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic step_to(input int target);
        if (target <= cyc) begin
            check("step_to_reachable", 32'(cyc), 32'(target - 1));
        end else begin
            step(target - cyc);
        end
    endtask

    // ------------------------------------------------------ test sequence
    initial begin
        int n1, s1, n3, s3;
        logic [0:0] e;

        n_checks = 0;
        n_fail   = 0;
        win_en   = 1'b0;
        clear_events();

        vec[0] = '{pads: 4'h1, hold: 20, gap: 60,  settles: 1'b1, exp_led: 4'h1,
                   exp_act: {8'd0, 8'd0, 8'd0, 8'd16},   exp_rise0: 1,  exp_rise1: 1};
        vec[1] = '{pads: 4'h2, hold: 4,  gap: 20,  settles: 1'b0, exp_led: 4'h0,
                   exp_act: {8'd0, 8'd0, 8'd0, 8'd0},    exp_rise0: 0,  exp_rise1: 0};
        vec[2] = '{pads: 4'h2, hold: 20, gap: 80,  settles: 1'b1, exp_led: 4'h2,
                   exp_act: {8'd0, 8'd0, 8'd32, 8'd0},   exp_rise0: 3,  exp_rise1: 3};
        vec[3] = '{pads: 4'h9, hold: 20, gap: 150, settles: 1'b1, exp_led: 4'h9,
                   exp_act: {8'd128, 8'd0, 8'd0, 8'd16}, exp_rise0: 32, exp_rise1: 30};
        vec[4] = '{pads: 4'h4, hold: 20, gap: 80,  settles: 1'b1, exp_led: 4'h4,
                   exp_act: {8'd0, 8'd64, 8'd0, 8'd0},   exp_rise0: 8,  exp_rise1: 8};

        // Reset with every pad held high: outputs stay low.
        rst_n = 1'b0;
        drum  = 4'hF;
        @(posedge sysclk);
        #1;
        step(3);
        check("reset_outputs",
              32'({bus0.led, bus0.active, bus0.speaker, bus0.gain, bus0.shutdown}), 32'd0);

        // Release with pads still high: they count as rising right after release.
        rst_n = 1'b1;
        for (int k = 0; k < NUM_CH; k++) mark_rise(k, 0);
        step(1);
        check("gain_after_release", 32'(bus0.gain), 32'd1);
        step(6);
        check("led_before_3_ticks", 32'(bus0.led), 32'h0);
        step(1);
        check("led_after_3_ticks", 32'(bus0.led), 32'hF);
        step_to(20);
        set_pads(4'h0, 1'b1);
        step(200);

        // Vector table.
        for (int i = 0; i < 5; i++) begin
            win_start();
            set_pads(vec[i].pads, vec[i].settles);
            step(vec[i].hold);
            set_pads(4'h0, vec[i].settles);
            step(vec[i].gap);
            win_en = 1'b0;
            check($sformatf("vec%0d_led_seen", i), 32'(led_seen), 32'(vec[i].exp_led));
            for (int k = 0; k < NUM_CH; k++) begin
                check($sformatf("vec%0d_active%0d_cycles", i, k),
                      32'(act_cnt[k]), 32'(vec[i].exp_act[k]));
            end
            check($sformatf("vec%0d_speaker0_rises", i), 32'(rise0), 32'(vec[i].exp_rise0));
            check($sformatf("vec%0d_speaker1_rises", i), 32'(rise1), 32'(vec[i].exp_rise1));
        end

        // Retrigger ch2 twenty ticks into its play.
        win_start();
        n1 = cyc;
        s1 = settle_edge(n1) + 2;
        set_pads(4'h4, 1'b1);
        step(20);
        set_pads(4'h0, 1'b1);
        step_to(n1 + 40);
        set_pads(4'h4, 1'b1);
        step(20);
        set_pads(4'h0, 1'b1);
        step(120);
        win_en = 1'b0;
        check("retrig_active2_cycles", 32'(act_cnt[2]), 32'd104);
        check("retrig_active2_falls",  32'(act2_falls), 32'd1);
        check("retrig_active2_last",   32'(last_act2),  32'(s1 + 40 + 63));

        // Priority: ch0 started while ch3 has four ticks left, outliving it.
        n3 = cyc;
        s3 = settle_edge(n3) + 2;
        set_pads(4'h8, 1'b1);
        step(20);
        set_pads(4'h0, 1'b1);
        step_to(n3 + 120);
        set_pads(4'h1, 1'b1);
        exp_q.push_back(1'b1);   // ch3 wave (tick 61) wins over ch0 wave (tick 1)
        exp_q.push_back(1'b1);   // ch3 done, ch0 wave at tick 5
        step_to(s3 + 123);
        e = exp_q.pop_front();
        check("prio_ch3_wins", 32'(bus0.speaker), 32'(e));
        step_to(s3 + 131);
        e = exp_q.pop_front();
        check("prio_ch0_after_ch3", 32'(bus0.speaker), 32'(e));
        check("prio_active_only_ch0", 32'(bus0.active), 32'h1);
        set_pads(4'h0, 1'b1);
        step(40);

        // Reset in the middle of a ch3 note.
        set_pads(4'h8, 1'b1);
        step(20);
        set_pads(4'h0, 1'b1);
        step(30);
        check("midplay_active3", 32'(bus0.active), 32'h8);
        rst_n = 1'b0;
        #1;
        check("midplay_reset_immediate",
              32'({bus0.led, bus0.active, bus0.speaker, bus0.gain, bus0.shutdown}), 32'd0);
        clear_events();
        @(posedge sysclk);
        #1;
        step(3);
        rst_n = 1'b1;
        step(60);
        check("after_reset_silent", 32'({bus0.active, bus0.speaker, bus0.shutdown}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
